// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle control FSM for the single-issue ARM-subset core. It owns every
// architectural write strobe (instruction register, PC, register file and the
// data-memory request) and steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), so the core commits state only when
// this block says so.
//
// Handshake: dmem_req is held high for every cycle spent in MEM; the request
// completes in the cycle where dmem_ack is sampled high at the clock edge.
// If no ack arrives within MEM_TIMEOUT MEM cycles the sequencer faults and
// parks in HALT.
//
// Parameters
//   MEM_TIMEOUT  MEM cycles allowed before a timeout fault (2..255)
//   CNT_W        width of the optional performance counters
//
// Ports
//   clk            core clock, all state on posedge
//   reset          asynchronous, active-high reset
//   branch_inst    decoder: current IR is a branch
//   data_inst      decoder: current IR is data-processing
//   load_inst      decoder: current IR is LDR
//   cond_execute   decoder: condition code passes
//   halt_req       request clean stop at next instruction boundary
//   dmem_ack       data memory completes the request this cycle
//   ir_we          load instruction register from code memory
//   pc_we          commit pc_next to pc_curr
//   pc_sel         0 = pc+4, 1 = branch target (meaningful when pc_we=1)
//   reg_we         register-file write enable
//   dmem_req       data-memory request, held until ack
//   state          FSM state encoding (debug port)
//   halted         sticky: sequencer is in HALT
//   fault          sticky: unknown instruction, memory timeout or bad state
//   retired_cnt    instructions retired (optional)
//   stall_cnt      MEM cycles without ack (optional)
//
// Optional feature macro: CPU_SEQ_PERF_EN
//   Defined   : retired_cnt / stall_cnt are live wrapping counters.
//   Undefined : both ports are tied to 0 and no counter flops exist.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_inst,
    input  logic             data_inst,
    input  logic             load_inst,
    input  logic             cond_execute,
    input  logic             halt_req,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             dmem_req,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Last value of the wait counter before a timeout is declared; the counter
    // starts at 0 on MEM entry, so this gives exactly MEM_TIMEOUT MEM cycles.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_halted;
    logic       r_fault;

    state_t     w_next_state;
    logic [7:0] w_wait_next;
    logic       w_set_fault;
    logic       w_ir_we;
    logic       w_pc_we;
    logic       w_pc_sel;
    logic       w_reg_we;
    logic       w_dmem_req;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            if (w_next_state == S_HALT) begin
                r_halted <= 1'b1;
            end
            if (w_set_fault) begin
                r_fault <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_set_fault  = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = 1'b0;
        w_reg_we     = 1'b0;
        w_dmem_req   = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Instruction boundary: the only place a halt is honoured.
                if (halt_req) begin
                    w_next_state = S_HALT;
                end else begin
                    w_ir_we      = 1'b1;
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                if (!cond_execute) begin
                    // Condition failed: retire as a no-op, advance PC.
                    w_pc_we      = 1'b1;
                    w_next_state = S_FETCH;
                end else if (branch_inst || load_inst || data_inst) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_set_fault  = 1'b1;
                    w_next_state = S_HALT;
                end
            end

            S_EXEC: begin
                // Priority branch > load > data.
                if (branch_inst) begin
                    w_pc_we      = 1'b1;
                    w_pc_sel     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (load_inst) begin
                    w_wait_next  = 8'd0;
                    w_next_state = S_MEM;
                end else if (data_inst) begin
                    w_next_state = S_WB;
                end else begin
                    // Decoder flags vanished after DECODE: treat as unknown.
                    w_set_fault  = 1'b1;
                    w_next_state = S_HALT;
                end
            end

            S_MEM: begin
                w_dmem_req = 1'b1;
                // Ack is checked first so it wins over a coincident timeout.
                if (dmem_ack) begin
                    w_next_state = S_WB;
                end else if (r_wait_cnt == TO_LAST) begin
                    w_set_fault  = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end

            S_WB: begin
                w_reg_we     = 1'b1;
                w_pc_we      = 1'b1;
                w_next_state = S_FETCH;
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                // Encodings 6 and 7 are unreachable in normal operation.
                w_set_fault  = 1'b1;
                w_next_state = S_HALT;
            end
        endcase
    end

    // Strobes are suppressed for the whole reset window; the state register
    // already reads FETCH there, which would otherwise raise ir_we.
    assign ir_we    = w_ir_we    & ~reset;
    assign pc_we    = w_pc_we    & ~reset;
    assign pc_sel   = w_pc_sel   & ~reset;
    assign reg_we   = w_reg_we   & ~reset;
    assign dmem_req = w_dmem_req & ~reset;

    assign state  = r_state;
    assign halted = r_halted;
    assign fault  = r_fault;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef CPU_SEQ_PERF_EN
    logic [CNT_W-1:0] r_retired_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Neither event can occur in HALT, so both counters freeze there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_pc_we) begin
                r_retired_cnt <= r_retired_cnt + 1'b1;
            end
            if ((r_state == S_MEM) && !dmem_ack) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Drives instruction scenarios into cpu_sequencer. A reference model turns each
// instruction (class, condition, memory wait count) into the expected per-cycle
// timeline of {state, ir_we, pc_we, pc_sel, reg_we, dmem_req} plus the stimulus
// (dmem_ack, halt_req) for that cycle. Sticky flags and counters are tracked by
// the model as plain tallies.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

    localparam int TO = 8;
    localparam int CW = 32;
    localparam int W  = 8;

`ifdef CPU_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Instruction classes used by the model.
    localparam int K_UNKNOWN = 0;
    localparam int K_BRANCH  = 1;
    localparam int K_DATA    = 2;
    localparam int K_LOAD    = 3;

    logic          clk;
    logic          reset;
    logic          branch_inst;
    logic          data_inst;
    logic          load_inst;
    logic          cond_execute;
    logic          halt_req;
    logic          dmem_ack;
    logic          ir_we;
    logic          pc_we;
    logic          pc_sel;
    logic          reg_we;
    logic          dmem_req;
    logic [2:0]    state;
    logic          halted;
    logic          fault;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] stall_cnt;

    cpu_sequencer #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .branch_inst  (branch_inst),
        .data_inst    (data_inst),
        .load_inst    (load_inst),
        .cond_execute (cond_execute),
        .halt_req     (halt_req),
        .dmem_ack     (dmem_ack),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .reg_we       (reg_we),
        .dmem_req     (dmem_req),
        .state        (state),
        .halted       (halted),
        .fault        (fault),
        .retired_cnt  (retired_cnt),
        .stall_cnt    (stall_cnt)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [1:0]   stim_q[$];  // {dmem_ack, halt_req}

    logic          m_fault;
    logic          m_halted;
    logic [CW-1:0] m_retired;
    logic [CW-1:0] m_stall;

    function automatic void push(input logic [2:0] st, input logic ir, input logic pw,
                                 input logic ps, input logic rw, input logic dr,
                                 input logic ack, input logic hreq);
        exp_q.push_back({st, ir, pw, ps & pw, rw, dr});
        stim_q.push_back({ack, hreq});
    endfunction

    // Expected timeline for one instruction. hreq is the halt_req level applied
    // after the FETCH cycle of this instruction.
    task automatic model_instr(input int kind, input bit cond, input int waits, input bit hreq);
        bit acked;
        push(ST_FETCH, 1, 0, 0, 0, 0, 0, 0);
        if (!cond) begin
            push(ST_DECODE, 0, 1, 0, 0, 0, 0, hreq);
            m_retired++;
            return;
        end
        push(ST_DECODE, 0, 0, 0, 0, 0, 0, hreq);
        if (kind == K_UNKNOWN) begin
            push(ST_HALT, 0, 0, 0, 0, 0, 0, hreq);
            push(ST_HALT, 0, 0, 0, 0, 0, 0, hreq);
            m_fault  = 1'b1;
            m_halted = 1'b1;
            return;
        end
        if (kind == K_BRANCH) begin
            push(ST_EXEC, 0, 1, 1, 0, 0, 0, hreq);
            m_retired++;
            return;
        end
        push(ST_EXEC, 0, 0, 0, 0, 0, 0, hreq);
        if (kind == K_LOAD) begin
            acked = 1'b0;
            for (int i = 0; i < TO && !acked; i++) begin
                acked = (i == waits);
                push(ST_MEM, 0, 0, 0, 0, 1, acked, hreq);
                if (!acked) m_stall++;
            end
            if (!acked) begin
                push(ST_HALT, 0, 0, 0, 0, 0, 0, hreq);
                push(ST_HALT, 0, 0, 0, 0, 0, 0, hreq);
                m_fault  = 1'b1;
                m_halted = 1'b1;
                return;
            end
        end
        push(ST_WB, 0, 1, 0, 1, 0, 0, hreq);
        m_retired++;
    endtask

    // A FETCH cycle that sees halt_req, followed by the parked HALT state.
    task automatic model_halt_fetch();
        push(ST_FETCH, 0, 0, 0, 0, 0, 0, 1);
        push(ST_HALT, 0, 0, 0, 0, 0, 0, 1);
        push(ST_HALT, 0, 0, 0, 0, 0, 0, 1);
        m_halted = 1'b1;
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic set_flags(input logic b, input logic d, input logic l, input logic c);
        branch_inst  = b;
        data_inst    = d;
        load_inst    = l;
        cond_execute = c;
    endtask

    // Applies the next stimulus entry, samples at the falling edge, then moves
    // to just after the following rising edge.
    task automatic next_cycle(output logic [W-1:0] obs, output logic [W-1:0] exp);
        logic [1:0] s;
        s = stim_q.pop_front();
        dmem_ack = s[1];
        halt_req = s[0];
        @(negedge clk);
        obs = {state, ir_we, pc_we, pc_sel & pc_we, reg_we, dmem_req};
        exp = exp_q.pop_front();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        halt_req = 1'b0;
        dmem_ack = 1'b0;
        set_flags(0, 0, 0, 0);
        exp_q.delete();
        stim_q.delete();
        m_fault   = 1'b0;
        m_halted  = 1'b0;
        m_retired = '0;
        m_stall   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset    = 1'b1;
        halt_req = 1'b0;
        dmem_ack = 1'b1;
        set_flags(1, 1, 1, 1);
        @(posedge clk);
        #1;
        checks++;
        if ({state, ir_we, pc_we, reg_we, dmem_req} !== {ST_FETCH, 4'b0000}) begin
            errors++;
            $display("FAIL reset_strobes: got %b required %b",
                     {state, ir_we, pc_we, reg_we, dmem_req}, {ST_FETCH, 4'b0000});
        end
        checks++;
        if ({halted, fault} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00", {halted, fault});
        end
        checks++;
        if ({retired_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", retired_cnt, stall_cnt);
        end
    endtask

    task automatic test_data();
        logic [W-1:0] obs, exp;
        int cyc;
        do_reset();
        set_flags(0, 1, 0, 1);
        model_instr(K_DATA, 1, 0, 0);
        model_instr(K_DATA, 1, 0, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL data cycle %0d: got %b required %b", cyc, obs, exp);
            end
            cyc++;
        end
        checks++;
        if (state !== ST_FETCH || fault !== 1'b0) begin
            errors++;
            $display("FAIL data_end: got state %0d fault %b required 0 0", state, fault);
        end
    endtask

    task automatic test_branch();
        logic [W-1:0] obs, exp;
        int cyc;
        do_reset();
        set_flags(1, 0, 0, 0);
        model_instr(K_BRANCH, 0, 0, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch_skip cycle %0d: got %b required %b", cyc, obs, exp);
            end
            cyc++;
        end
        set_flags(1, 1, 1, 1);  // branch has priority over load and data
        model_instr(K_BRANCH, 1, 0, 0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch_taken cycle %0d: got %b required %b", cyc, obs, exp);
            end
            cyc++;
        end
    endtask

    task automatic test_load_wait();
        logic [W-1:0] obs, exp;
        int cyc;
        int req_cycles;
        do_reset();
        set_flags(0, 1, 1, 1);  // load has priority over data
        model_instr(K_LOAD, 1, 5, 0);
        cyc = 0;
        req_cycles = 0;
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            if (obs[0]) req_cycles++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_wait cycle %0d: got %b required %b", cyc, obs, exp);
            end
            cyc++;
        end
        checks++;
        if (req_cycles !== 6) begin
            errors++;
            $display("FAIL load_req_len: got %0d required 6", req_cycles);
        end
        checks++;
        if (retired_cnt !== (PERF ? m_retired : '0) || stall_cnt !== (PERF ? m_stall : '0)) begin
            errors++;
            $display("FAIL load_counters: got %0d/%0d required %0d/%0d", retired_cnt, stall_cnt,
                     PERF ? m_retired : '0, PERF ? m_stall : '0);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] obs, exp;
        logic [2:0] f;
        int kind;
        bit cond;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(1, 7));  // {branch, load, data}, never all zero
            cond = ($urandom_range(0, 9) < 7);
            kind = f[2] ? K_BRANCH : (f[1] ? K_LOAD : K_DATA);
            set_flags(f[2], f[0], f[1], cond);
            model_instr(kind, cond, $urandom_range(0, TO - 1), 0);
            while (exp_q.size() > 0) begin
                next_cycle(obs, exp);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random instr %0d: got %b required %b", n, obs, exp);
                end
            end
        end
        checks++;
        if (retired_cnt !== (PERF ? m_retired : '0) || stall_cnt !== (PERF ? m_stall : '0)) begin
            errors++;
            $display("FAIL random_counters: got %0d/%0d required %0d/%0d", retired_cnt, stall_cnt,
                     PERF ? m_retired : '0, PERF ? m_stall : '0);
        end
        checks++;
        if ({halted, fault} !== 2'b00) begin
            errors++;
            $display("FAIL random_flags: got %b required 00", {halted, fault});
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] obs, exp;
        do_reset();
        set_flags(0, 0, 1, 1);
        model_instr(K_LOAD, 1, TO, 0);  // ack never arrives
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout: got %b required %b", obs, exp);
            end
        end
        checks++;
        if (fault !== m_fault || state !== ST_HALT) begin
            errors++;
            $display("FAIL timeout_fault: got fault %b state %0d required %b 5", fault, state, m_fault);
        end
        checks++;
        if (stall_cnt !== (PERF ? m_stall : '0) || retired_cnt !== (PERF ? m_retired : '0)) begin
            errors++;
            $display("FAIL timeout_counters: got %0d/%0d required %0d/%0d", retired_cnt, stall_cnt,
                     PERF ? m_retired : '0, PERF ? m_stall : '0);
        end

        do_reset();
        set_flags(0, 0, 1, 1);
        model_instr(K_LOAD, 1, TO - 1, 0);  // ack on the last allowed cycle
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL late_ack: got %b required %b", obs, exp);
            end
        end
        checks++;
        if (fault !== 1'b0 || state !== ST_FETCH) begin
            errors++;
            $display("FAIL late_ack_end: got fault %b state %0d required 0 0", fault, state);
        end
    endtask

    task automatic test_halt();
        logic [W-1:0] obs, exp;
        do_reset();
        set_flags(0, 1, 0, 1);
        model_instr(K_DATA, 1, 0, 1);  // halt_req raised from DECODE onward
        model_halt_fetch();
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL halt: got %b required %b", obs, exp);
            end
        end
        checks++;
        if ({halted, fault} !== {m_halted, m_fault}) begin
            errors++;
            $display("FAIL halt_flags: got %b required %b", {halted, fault}, {m_halted, m_fault});
        end
        checks++;
        if (retired_cnt !== (PERF ? m_retired : '0)) begin
            errors++;
            $display("FAIL halt_retired: got %0d required %0d", retired_cnt, PERF ? m_retired : '0);
        end
    endtask

    task automatic test_unknown();
        logic [W-1:0] obs, exp;
        do_reset();
        set_flags(0, 0, 0, 1);
        model_instr(K_UNKNOWN, 1, 0, 0);
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL unknown: got %b required %b", obs, exp);
            end
        end
        checks++;
        if (fault !== m_fault || state !== ST_HALT) begin
            errors++;
            $display("FAIL unknown_fault: got fault %b state %0d required %b 5", fault, state, m_fault);
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [W-1:0] obs, exp;
        do_reset();
        set_flags(0, 0, 1, 1);
        model_instr(K_LOAD, 1, TO, 0);
        // FETCH, DECODE, EXEC and three MEM cycles; the fourth MEM cycle is
        // then interrupted by reset.
        for (int i = 0; i < 6; i++) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_mem cycle %0d: got %b required %b", i, obs, exp);
            end
        end
        exp_q.delete();
        stim_q.delete();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({state, ir_we, pc_we, reg_we, dmem_req, fault} !== {ST_FETCH, 5'b00000}) begin
            errors++;
            $display("FAIL mid_mem_reset: got %b required %b",
                     {state, ir_we, pc_we, reg_we, dmem_req, fault}, {ST_FETCH, 5'b00000});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({reg_we, pc_we, dmem_req} !== 3'b000) begin
                errors++;
                $display("FAIL mid_mem_hold: got %b required 000", {reg_we, pc_we, dmem_req});
            end
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_fault   = 1'b0;
        m_halted  = 1'b0;
        m_retired = '0;
        m_stall   = '0;
        set_flags(0, 1, 0, 1);
        model_instr(K_DATA, 1, 0, 0);
        while (exp_q.size() > 0) begin
            next_cycle(obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL after_reset: got %b required %b", obs, exp);
            end
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        reset        = 1'b1;
        halt_req     = 1'b0;
        dmem_ack     = 1'b0;
        branch_inst  = 1'b0;
        data_inst    = 1'b0;
        load_inst    = 1'b0;
        cond_execute = 1'b0;
        test_reset();
        test_data();
        test_branch();
        test_load_wait();
        test_random();
        test_timeout();
        test_halt();
        test_unknown();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
